// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: default sizes, opcodes, FSM states.
package stack_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int W_DEF     = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_PUSH = 3'b001,
    OP_POP  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_DUP  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    READ = 2'd2
  } state_e;

endpackage

// File: rtl/stack_alu.sv
// Combinational add/subtract, result wraps modulo 2^W.
module stack_alu #(
  parameter int W = stack_pkg::W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  // a - b when sub is set, otherwise a + b
  always_comb begin
    y = sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/stack_sequencer.sv
// Command sequencer for a stack kept in an external RAM. The top entry is
// cached in tos so PUSH/DUP/single-entry POP finish without a RAM read;
// POP/ADD/SUB on deeper stacks read the entry below the top first.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [W-1:0]             cmd_data,
  output logic [$clog2(DEPTH)-1:0] st_addr,
  output logic                     st_wren,
  output logic [W-1:0]             st_wdata,
  input  logic [W-1:0]             st_rdata,
  output logic [W-1:0]             tos,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     done,
  output logic                     err_ovf,
  output logic                     err_unf,
  output logic                     err_ill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  op_e           op_q;
  logic [W-1:0]  data_q;
  logic [AW:0]   depth_q, depth_d;
  logic [W-1:0]  tos_q, tos_d;

  logic [AW-1:0] depth_lo;
  logic [AW-1:0] addr_m2;
  logic          is_full;
  logic          is_empty;
  logic          has_two;
  logic          needs_read;
  logic          alu_sub;
  logic [W-1:0]  alu_y;

  assign depth_lo = depth_q[AW-1:0];
  assign addr_m2  = depth_lo - AW'(2);
  assign is_full  = (depth_q == FULL);
  assign is_empty = (depth_q == '0);
  assign has_two  = (depth_q >= (AW+1)'(2));
  assign alu_sub  = (op_q == OP_SUB);
  assign needs_read = has_two &&
                      (op_q == OP_POP || op_q == OP_ADD || op_q == OP_SUB);

  stack_alu #(.W(W)) u_alu (
    .a   (st_rdata),
    .b   (tos_q),
    .sub (alu_sub),
    .y   (alu_y)
  );

  // State register; reset aborts any command in flight
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: accept in IDLE, detour through READ only when the second entry is needed
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid && cmd_ready) state_d = EXEC;
      EXEC:    state_d = needs_read ? READ : IDLE;
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values; reset forces every output quiet
  always_comb begin
    cmd_ready = (state_q == IDLE);
    st_addr   = '0;
    st_wren   = 1'b0;
    st_wdata  = '0;
    done      = 1'b0;
    err_ovf   = 1'b0;
    err_unf   = 1'b0;
    err_ill   = 1'b0;
    depth_d   = depth_q;
    tos_d     = tos_q;
    unique case (state_q)
      EXEC: begin
        case (op_q)
          OP_NOP: done = 1'b1;
          OP_PUSH: begin
            done = 1'b1;
            if (is_full) begin
              err_ovf = 1'b1;
            end else begin
              st_wren  = 1'b1;
              st_addr  = depth_lo;
              st_wdata = data_q;
              depth_d  = depth_q + 1'b1;
              tos_d    = data_q;
            end
          end
          OP_DUP: begin
            done = 1'b1;
            if (is_empty) begin
              err_unf = 1'b1;
            end else if (is_full) begin
              err_ovf = 1'b1;
            end else begin
              st_wren  = 1'b1;
              st_addr  = depth_lo;
              st_wdata = tos_q;
              depth_d  = depth_q + 1'b1;
            end
          end
          OP_POP: begin
            if (has_two) begin
              st_addr = addr_m2;
            end else if (is_empty) begin
              done    = 1'b1;
              err_unf = 1'b1;
            end else begin
              done    = 1'b1;
              depth_d = '0;
              tos_d   = '0;
            end
          end
          OP_ADD, OP_SUB: begin
            if (has_two) begin
              st_addr = addr_m2;
            end else begin
              done    = 1'b1;
              err_unf = 1'b1;
            end
          end
          default: begin
            done    = 1'b1;
            err_ill = 1'b1;
          end
        endcase
      end
      READ: begin
        done    = 1'b1;
        depth_d = depth_q - 1'b1;
        if (op_q == OP_POP) begin
          tos_d = st_rdata;
        end else begin
          st_wren  = 1'b1;
          st_addr  = addr_m2;
          st_wdata = alu_y;
          tos_d    = alu_y;
        end
      end
      default: ;
    endcase
    if (reset) begin
      cmd_ready = 1'b0;
      st_addr   = '0;
      st_wren   = 1'b0;
      st_wdata  = '0;
      done      = 1'b0;
      err_ovf   = 1'b0;
      err_unf   = 1'b0;
      err_ill   = 1'b0;
    end
  end

  // Command latch on handshake; contents only matter while not IDLE
  always_ff @(posedge clock) begin
    if (cmd_valid && cmd_ready) begin
      op_q   <= op_e'(cmd_op);
      data_q <= cmd_data;
    end
  end

  // Cached top-of-stack and entry count
  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q <= '0;
      tos_q   <= '0;
    end else begin
      depth_q <= depth_d;
      tos_q   <= tos_d;
    end
  end

  assign tos   = tos_q;
  assign depth = depth_q;

endmodule
